// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory: one transaction at a time,
// round-robin or fixed-A priority, one-cycle ack pulse carrying read data.
//
// state | meaning
// IDLE  | no transaction; arbitrate sampled requests
// ISSUE | one-cycle memory strobe with the latched command
// WAIT  | count out the memory read latency, then capture read data
// ACK   | one-cycle ack to the owner; remember owner for round-robin
module mem_port_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t        state, state_nxt;
  logic          owner_q, last_q, we_q, grant_b;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, a_rdata_q, b_rdata_q;
  logic [2:0]    cnt_q;

  // On a tie, round-robin hands the grant to whichever port did not go last.
  always_comb begin
    grant_b = 1'b0;
    if (b_req && !a_req)
      grant_b = 1'b1;
    else if (a_req && b_req && FIXED_PRI == 0)
      grant_b = !last_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (a_req || b_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt_q == LAT) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (a_req || b_req) begin
          owner_q <= grant_b;
          we_q    <= grant_b ? b_we    : a_we;
          addr_q  <= grant_b ? b_addr  : a_addr;
          wdata_q <= grant_b ? b_wdata : a_wdata;
        end
        ISSUE: cnt_q <= 3'd1;
        WAIT: begin
          if (cnt_q == LAT) begin
            if (owner_q) b_rdata_q <= mem_rdata;
            else         a_rdata_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ACK: last_q <= owner_q;
        default: ;
      endcase
    end
  end

  // Command registers drive the memory directly so they stay stable through WAIT.
  assign mem_en    = (state == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign a_ack     = (state == ACK) && !owner_q;
  assign b_ack     = (state == ACK) &&  owner_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = (state != IDLE);
  assign owner     = owner_q;

endmodule
